am_mod_stream: RTL
==================

Name: am_mod_stream

Overview:
- Streaming AM modulator. It is the transmit-side counterpart of the AM demodulation chain.
- It accepts signed 8-bit baseband samples over a valid/ready handshake at a fixed baseband rate.
- It generates the carrier with a phase-accumulator NCO and a quarter-wave sine LUT, and outputs signed 16-bit AM samples (DC-offset envelope × carrier) every clock at the 100 MHz system rate.
- Its output feeds the DAC path or drives the demodulator directly in loopback.

Parameters:
- PHASE_W, 32, phase accumulator width.
- FCW_DEFAULT, 429496730, reset carrier tuning word (10 MHz at 100 MHz clk).
- RATE_DIV, 100, clocks per baseband sample (1 MHz baseband), ≥2.
- DC_OFFSET, 128, envelope offset added to the baseband sample.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous, active-high reset.
- en  in  1  global enable; low stalls the whole block.
- fcw_wr  in  1  load strobe for fcw_data.
- fcw_data  in  PHASE_W  new tuning word.
- in_valid  in  1  baseband sample valid.
- in_data  in  8  signed baseband sample.
- in_ready  out  1  block accepts a sample this cycle.
- underrun  out  1  one-cycle pulse: no sample available at the rate strobe.
- out_valid  out  1  out_data is valid.
- out_data  out  16  signed AM output.

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst.
- Reset values (rst sampled high at an edge):
  - phase_acc=0, fcw=FCW_DEFAULT.
  - env=DC_OFFSET (s=0), divider count=0.
  - Pipeline registers=0.
  - out_data=0, out_valid=0, in_ready=0, underrun=0.
- Reset behaviour: rst beats every other input, including fcw_wr and in_valid. Reset mid-operation discards the pipeline contents and any pending sample.
- Tuning word: fcw_wr=1 loads fcw from fcw_data at the edge, independent of en. The new increment takes effect on the next accumulation. The phase is not cleared.
- NCO, every edge with en=1: phase_acc <= phase_acc + fcw, modulo 2^PHASE_W.
- Carrier pipeline (each stage advances only when en=1):
  - S1 registers p = phase_acc[PHASE_W-1 -: 8], giving quadrant q=p[7:6] and index i=p[5:0].
  - S2 registers the LUT read. The address is i for q=0 and q=2, and 63-i for q=1 and q=3.
  - LUT contents: lut[k] = round(127·sin(2π(k+0.5)/256)), k=0..63, unsigned 7-bit, range 2..127.
  - S3 registers the signed 8-bit sine: +lut for q=0/1, −lut for q=2/3.
  - S4 registers out_data = $signed({1'b0,env}) × sine, as a 16-bit signed result. The envelope range 0..255 times |sine|≤127 gives a maximum magnitude of 32385, so there is no overflow and no saturation logic.
- Latency: a phase_acc value present after edge k appears at out_data after edge k+4 (en held high).
- Baseband divider:
  - The counter increments modulo RATE_DIV on each en=1 edge.
  - in_ready = en && (count == RATE_DIV-1), a registered-state decode.
  - Transfer occurs when in_valid && in_ready. At that edge, env <= DC_OFFSET + in_data (signed add, result 0..255, 9-bit unsigned).
  - The new env is used by S4 at the following edge.
  - If in_ready=1 and in_valid=0: env holds its previous value and underrun pulses high for exactly one cycle (the following cycle).
  - in_valid is ignored when in_ready=0. The source holds the data until ready.
  - The first in_ready after reset occurs in the RATE_DIV-th cycle after reset release.
- Valid tracking:
  - A 4-bit valid shift register fills with 1s on en=1 edges. It is cleared by rst only.
  - out_valid <= shreg[3] && en.
  - en low: all state freezes, out_data holds, out_valid=0 from the next edge. On en returning high, out_valid rises at the next edge with no re-fill.
- Wrap-around: the phase wraps silently, with no glitch at the 2π boundary. The divider wraps RATE_DIV-1 → 0.

Test Plan:
- Reset, FCW_DEFAULT, in_valid=0: out_valid=0 for 4 cycles after release, then 1. out_data is continuous.
  - Baseband stays s=0 (env=128). Expected S3 sine sequence (phase-accumulator top-byte steps of ~25.6) follows LUT values ±(2..127); out_data = 128×sine.
  - underrun pulses every 100 cycles.
- Load fcw=2^30 right after reset, feed s=+127 at the first ready: env=255. out_data cycles 510, 32385, −510, −32385 repeating.
- Feed s=−128: env=0 → out_data=0 every cycle. Feed s=0 → peaks ±16256 (128×127).
- Handshake: hold in_valid=1 with incrementing data. Exactly one transfer per 100 cycles, in_ready high for one cycle each time, no underrun. Drop in_valid for one strobe: underrun=1 one cycle, env unchanged.
- en low for 10 cycles mid-stream: out_data frozen, out_valid=0, phase and divider frozen. Resumes with out_valid=1 at the first edge after en returns high; the sequence continues exactly where it stopped.
- Assert rst mid-stream together with fcw_wr and in_valid&&in_ready: all outputs return to their reset values, fcw=FCW_DEFAULT, no sample accepted.

Source files
------------

// File: rtl/am_mod_stream_if.sv
// Baseband-in / AM-out stream bundle for am_mod_stream.
// master = sample source and output consumer, slave = the modulator.
interface am_mod_stream_if;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        underrun;
  logic        out_valid;
  logic [15:0] out_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  underrun,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output underrun,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/am_mod_stream.sv
// Streaming AM modulator: NCO + quarter-wave sine LUT carrier times DC-offset envelope.
// Latency 4 clocks phase->out_data; output never backpressured, input paced one sample per RATE_DIV clocks via in_ready, en low stalls everything.
module am_mod_stream #(
  parameter int unsigned PHASE_W     = 32,
  parameter int unsigned FCW_DEFAULT = 429496730,
  parameter int unsigned RATE_DIV    = 100,
  parameter int unsigned DC_OFFSET   = 128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               fcw_wr,
  input  logic [PHASE_W-1:0] fcw_data,
  am_mod_stream_if.slave     bus
);

  localparam int unsigned CNT_W = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(RATE_DIV - 1);

  logic [PHASE_W-1:0] fcw;
  logic [PHASE_W-1:0] phase_acc;
  logic [7:0]         s1_p;
  logic [1:0]         s2_q;
  logic [6:0]         s2_mag;
  logic signed [7:0]  s3_sine;
  logic [8:0]         env;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         fill;
  logic [15:0]        out_data_r;
  logic               out_valid_r;
  logic               underrun_r;

  logic [5:0]         lut_addr;
  logic [6:0]         lut_rd;
  logic signed [7:0]  sine_nxt;
  logic signed [15:0] am_prod;
  logic [8:0]         env_sum;
  logic               take;

  // Odd quadrants walk the quarter wave backwards: 63-i == ~i.
  assign lut_addr = s1_p[6] ? ~s1_p[5:0] : s1_p[5:0];

  always_comb begin
    lut_rd = 7'd0;
    case (lut_addr)
      6'd0:  lut_rd = 7'd2;
      6'd1:  lut_rd = 7'd5;
      6'd2:  lut_rd = 7'd8;
      6'd3:  lut_rd = 7'd11;
      6'd4:  lut_rd = 7'd14;
      6'd5:  lut_rd = 7'd17;
      6'd6:  lut_rd = 7'd20;
      6'd7:  lut_rd = 7'd23;
      6'd8:  lut_rd = 7'd26;
      6'd9:  lut_rd = 7'd29;
      6'd10: lut_rd = 7'd32;
      6'd11: lut_rd = 7'd35;
      6'd12: lut_rd = 7'd38;
      6'd13: lut_rd = 7'd41;
      6'd14: lut_rd = 7'd44;
      6'd15: lut_rd = 7'd47;
      6'd16: lut_rd = 7'd50;
      6'd17: lut_rd = 7'd53;
      6'd18: lut_rd = 7'd56;
      6'd19: lut_rd = 7'd58;
      6'd20: lut_rd = 7'd61;
      6'd21: lut_rd = 7'd64;
      6'd22: lut_rd = 7'd67;
      6'd23: lut_rd = 7'd69;
      6'd24: lut_rd = 7'd72;
      6'd25: lut_rd = 7'd74;
      6'd26: lut_rd = 7'd77;
      6'd27: lut_rd = 7'd79;
      6'd28: lut_rd = 7'd82;
      6'd29: lut_rd = 7'd84;
      6'd30: lut_rd = 7'd86;
      6'd31: lut_rd = 7'd89;
      6'd32: lut_rd = 7'd91;
      6'd33: lut_rd = 7'd93;
      6'd34: lut_rd = 7'd95;
      6'd35: lut_rd = 7'd97;
      6'd36: lut_rd = 7'd99;
      6'd37: lut_rd = 7'd101;
      6'd38: lut_rd = 7'd103;
      6'd39: lut_rd = 7'd105;
      6'd40: lut_rd = 7'd106;
      6'd41: lut_rd = 7'd108;
      6'd42: lut_rd = 7'd110;
      6'd43: lut_rd = 7'd111;
      6'd44: lut_rd = 7'd113;
      6'd45: lut_rd = 7'd114;
      6'd46: lut_rd = 7'd115;
      6'd47: lut_rd = 7'd117;
      6'd48: lut_rd = 7'd118;
      6'd49: lut_rd = 7'd119;
      6'd50: lut_rd = 7'd120;
      6'd51: lut_rd = 7'd121;
      6'd52: lut_rd = 7'd122;
      6'd53: lut_rd = 7'd123;
      6'd54: lut_rd = 7'd124;
      6'd55: lut_rd = 7'd124;
      6'd56: lut_rd = 7'd125;
      6'd57: lut_rd = 7'd125;
      6'd58: lut_rd = 7'd126;
      6'd59: lut_rd = 7'd126;
      6'd60: lut_rd = 7'd127;
      6'd61: lut_rd = 7'd127;
      6'd62: lut_rd = 7'd127;
      6'd63: lut_rd = 7'd127;
    endcase
  end

  // Lower half-cycle (q=2,3) negates the magnitude.
  always_comb begin
    sine_nxt = $signed({1'b0, s2_mag});
    if (s2_q[1]) begin
      sine_nxt = -$signed({1'b0, s2_mag});
    end
  end

  // |env*sine| <= 255*127 fits in 16 signed bits, so wrap-free truncation.
  assign am_prod = 16'($signed({1'b0, env})) * 16'(s3_sine);

  assign env_sum = 9'(DC_OFFSET) + {bus.in_data[7], bus.in_data};

  assign bus.in_ready = en && (cnt == CNT_MAX);
  assign take         = bus.in_ready && bus.in_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      fcw         <= PHASE_W'(FCW_DEFAULT);
      phase_acc   <= '0;
      s1_p        <= '0;
      s2_q        <= '0;
      s2_mag      <= '0;
      s3_sine     <= '0;
      env         <= 9'(DC_OFFSET);
      cnt         <= '0;
      fill        <= '0;
      out_data_r  <= '0;
      out_valid_r <= 1'b0;
      underrun_r  <= 1'b0;
    end else begin
      if (fcw_wr) begin
        fcw <= fcw_data;
      end
      underrun_r <= bus.in_ready && !bus.in_valid;
      // out_valid is itself the fourth stage of the fill chain.
      out_valid_r <= en && fill[2];
      if (en) begin
        phase_acc  <= phase_acc + fcw;
        s1_p       <= phase_acc[PHASE_W-1 -: 8];
        s2_q       <= s1_p[7:6];
        s2_mag     <= lut_rd;
        s3_sine    <= sine_nxt;
        out_data_r <= am_prod;
        fill       <= {fill[1:0], 1'b1};
        cnt        <= (cnt == CNT_MAX) ? '0 : cnt + CNT_W'(1);
        if (take) begin
          env <= env_sum;
        end
      end
    end
  end

  assign bus.out_data  = out_data_r;
  assign bus.out_valid = out_valid_r;
  assign bus.underrun  = underrun_r;

endmodule
